// File: rtl/pipe_pkg.sv
// Shared types for destination-register tracking: stage tag layout, bubble value, R15 index.
package pipe_pkg;

  localparam int unsigned REG_AW   = 4;
  localparam int unsigned NUM_REGS = 16;

  typedef logic [REG_AW-1:0] reg_addr_t;

  localparam reg_addr_t PC_REG = 4'd15;

  typedef struct packed {
    logic      regwrite;
    logic      memtoreg;
    reg_addr_t wa;
  } dest_tag_t;

  localparam dest_tag_t BUBBLE_TAG = '{regwrite: 1'b0, memtoreg: 1'b0, wa: 4'd0};

  // One-hot of the register a tag will write; bubbles map to zero.
  function automatic logic [NUM_REGS-1:0] dest_mask(input dest_tag_t t);
    logic [NUM_REGS-1:0] m;
    m = '0;
    if (t.regwrite) m[t.wa] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/dest_stage_reg.sv
// One pipeline-stage destination tag: synchronous clear to bubble wins over hold.
module dest_stage_reg
  import pipe_pkg::*;
(
  input  logic      clk,
  input  logic      clr_i,
  input  logic      hold_i,
  input  dest_tag_t tag_i,
  output dest_tag_t tag_o
);

  dest_tag_t tag_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      tag_q <= BUBBLE_TAG;
    end else if (!hold_i) begin
      tag_q <= tag_i;
    end
  end

  assign tag_o = tag_q;

endmodule

// File: rtl/writeback_tracker.sv
// Tracks in-flight register destinations E/M/W, memory-wait stall and a sticky wait timeout.
// Optional PC_HAZARD_EN: drives pc_pending from in-flight writes to R15; otherwise tied low.
module writeback_tracker
  import pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  WA3D,
  input  logic        RegWriteD,
  input  logic        MemtoRegD,
  input  logic        StallD,
  input  logic        FlushE,
  input  logic        MemReadyM,
  output logic [3:0]  WA3E,
  output logic [3:0]  WA3M,
  output logic [3:0]  WA3W,
  output logic        RegWriteE,
  output logic        RegWriteM,
  output logic        RegWriteW,
  output logic        MemtoRegE,
  output logic        MemtoRegM,
  output logic        mem_stall,
  output logic [15:0] pending,
  output logic        pc_pending,
  output logic        mem_timeout
);

  localparam int unsigned     CNT_W       = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  dest_tag_t tag_d;
  dest_tag_t tag_e_q;
  dest_tag_t tag_m_q;
  dest_tag_t tag_w_q;

  logic             clr_e;
  logic             clr_w;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_d;
  logic             timeout_q;

  assign tag_d     = '{regwrite: RegWriteD, memtoreg: MemtoRegD, wa: WA3D};
  assign mem_stall = tag_m_q.regwrite & tag_m_q.memtoreg & ~MemReadyM;

  // A waiting load keeps Execute alive even under FlushE; Writeback gets bubbles so the load writes once.
  assign clr_e = reset | (~mem_stall & (FlushE | StallD));
  assign clr_w = reset | mem_stall;

  dest_stage_reg u_stage_e (
    .clk    (clk),
    .clr_i  (clr_e),
    .hold_i (mem_stall),
    .tag_i  (tag_d),
    .tag_o  (tag_e_q)
  );

  dest_stage_reg u_stage_m (
    .clk    (clk),
    .clr_i  (reset),
    .hold_i (mem_stall),
    .tag_i  (tag_e_q),
    .tag_o  (tag_m_q)
  );

  dest_stage_reg u_stage_w (
    .clk    (clk),
    .clr_i  (clr_w),
    .hold_i (1'b0),
    .tag_i  (tag_m_q),
    .tag_o  (tag_w_q)
  );

  // Saturating wait counter; the flag sets on the edge the count reaches the limit.
  always_comb begin
    cnt_d     = '0;
    timeout_d = timeout_q;
    if (mem_stall) begin
      cnt_d = (cnt_q == TIMEOUT_CNT) ? cnt_q : cnt_q + CNT_W'(1);
    end
    if (cnt_d == TIMEOUT_CNT) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign WA3E        = tag_e_q.wa;
  assign WA3M        = tag_m_q.wa;
  assign WA3W        = tag_w_q.wa;
  assign RegWriteE   = tag_e_q.regwrite;
  assign RegWriteM   = tag_m_q.regwrite;
  assign RegWriteW   = tag_w_q.regwrite;
  assign MemtoRegE   = tag_e_q.memtoreg;
  assign MemtoRegM   = tag_m_q.memtoreg;
  assign mem_timeout = timeout_q;

  assign pending = dest_mask(tag_e_q) | dest_mask(tag_m_q) | dest_mask(tag_w_q);

`ifdef PC_HAZARD_EN
  assign pc_pending = pending[PC_REG];
`else
  assign pc_pending = 1'b0;
`endif

endmodule

// File: doc/writeback_tracker.md
# writeback_tracker

Tracks every in-flight register destination from Decode through Writeback, producing the write-address and write-enable tags (WA3E/WA3M/WA3W, RegWriteM/W, MemtoRegE) consumed by the forwarding/stall logic. Consumes that logic's StallD/FlushE, and adds a memory-wait stall for the multi-cycle data memory. Sits beside the datapath pipeline registers in the Filter-GPU pipeline; its stage tags advance in lockstep with them.

## Interface
- MEM_TIMEOUT, default 255: consecutive memory-wait cycles before `mem_timeout` is raised (1..255).
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- WA3D  in  4  destination register of instruction in Decode.
- RegWriteD  in  1  Decode instruction writes a register.
- MemtoRegD  in  1  Decode instruction is a load.
- StallD  in  1  Decode held (from stall logic); Decode tag not consumed.
- FlushE  in  1  insert bubble into Execute.
- MemReadyM  in  1  data memory returns load data this cycle.
- WA3E / WA3M / WA3W  out  4 each  destination tag per stage.
- RegWriteE / RegWriteM / RegWriteW  out  1 each  stage writes a register.
- MemtoRegE / MemtoRegM  out  1 each  stage holds a load.
- mem_stall  out  1  Memory stage waiting on data; top ORs into StallF/StallD and holds Execute/Memory.
- pending  out  16  bit r set if any of E/M/W writes register r.
- pc_pending  out  1  in-flight write to R15 (see Configuration).
- mem_timeout  out  1  sticky wait-timeout flag.

## Operation
- Stage tag = {regwrite, memtoreg, wa}. Bubble = all zero.
- mem_stall = RegWriteM & MemtoRegM & !MemReadyM (combinational).
- Execute tag, per edge, by priority: reset -> bubble; mem_stall -> hold; FlushE -> bubble; StallD -> bubble; else load {RegWriteD, MemtoRegD, WA3D}.
- Memory tag: reset -> bubble; mem_stall -> hold; else load Execute tag.
- Writeback tag: reset -> bubble; mem_stall -> bubble (the stalled load must not write twice); else load Memory tag.
- pending[r] = OR over stages s of (RegWrite_s & WA3_s == r). Bubbles contribute nothing.
- Wait counter, 8 bits: cleared on reset or when mem_stall is low; increments each mem_stall cycle, saturating at MEM_TIMEOUT. When it equals MEM_TIMEOUT, mem_timeout sets and stays set until reset. The stall is not released by timeout.
- Simultaneous FlushE and mem_stall: hold wins. The Execute instruction is valid and must survive the wait.
- Reset mid-wait: all tags become bubbles, counter clears, and mem_timeout clears in the same edge.

## Timing
- Every output except mem_stall, pending and pc_pending is a register output. Reset value of all outputs is 0.
- Decode-to-Execute is 1 cycle, Execute-to-Memory is 1 cycle, and Memory-to-Writeback is 1 cycle. A load with MemReadyM high on first Memory cycle has zero added latency.
- Load waiting N cycles produces N mem_stall cycles and N Writeback bubbles. It reaches Writeback on the edge after MemReadyM rises.
- mem_stall, pending and pc_pending are combinational from the stage registers and MemReadyM. No combinational path exists from StallD/FlushE to outputs.

## Configuration
- PC_HAZARD_EN defined: pc_pending = OR over E/M/W of (RegWrite_s & WA3_s == 15). The top uses it to hold Fetch until R15 writes retire.
- Undefined: pc_pending tied 0. No R15 compare logic is synthesized, and pending[15] still functions.

## Structure
- pipe_pkg: typedef reg_addr_t (logic [3:0]), constant PC_REG = 4'd15, packed struct dest_tag_t {regwrite, memtoreg, wa}, constant BUBBLE_TAG.
- Sub-module dest_stage_reg, a dest_tag_t register with synchronous clear (reset/bubble) and hold enable, instantiated three times. The counter and decode logic stay in the top module.

## Test plan
- Straight-line: RegWriteD=1, WA3D=3 for one cycle -> WA3E=3 at cycle 1, WA3M=3 at cycle 2, WA3W=3 at cycle 3. pending[3] is high for cycles 1–3 only.
- Load wait: load WA3D=5, MemReadyM low 3 cycles in Memory -> mem_stall high 3 cycles, WA3M held at 5, RegWriteW=0 those cycles. RegWriteW=1, WA3W=5 one cycle after MemReadyM rises.
- FlushE during mem_stall: Execute holds WA3E=7 across the wait. With FlushE alone (no mem_stall), RegWriteE=0 next cycle.
- Timeout: MEM_TIMEOUT=4, MemReadyM held low -> mem_timeout rises after 4th stall cycle and stays high after MemReadyM returns. Reset clears it.
- Reset mid-operation: tags in all three stages, then reset asserted one cycle -> all outputs 0 next cycle, pending=16'h0000.
- PC tracking: write to R15 issued, with PC_HAZARD_EN defined -> pc_pending high 3 cycles. Without it -> pc_pending constant 0.
